hash_bucket_queue: RTL and testbench
====================================

# hash_bucket_queue

Downstream stage of the universal hash pipeline. Accepts one (hash, ID) pair per cycle, folds the 32-bit hash into an SRAM bucket address, and buffers the requests in a circular FIFO. Requests are issued to the SRAM process-table lookup over a valid/ready handshake. The block absorbs SRAM backpressure so the hash pipeline never stalls; it drops on overflow and flags every drop.

## Interface
Parameters:
- `ADDR_W`, default 19: bucket address width; legal range 8..20.
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries; legal range 2..8.

Ports:
- `axi_aclk` in 1: sole clock.
- `axi_aresetn` in 1: reset. Synchronous and active-high, despite the name.
- `hash_valid` in 1: qualifies `hash_data` and `hash_id` in the same cycle.
- `hash_data` in 32: universal hash value.
- `hash_id` in 32: key ID aligned with `hash_data`.
- `req_valid` out 1: FIFO head is valid.
- `req_ready` in 1: SRAM side accepts the head this cycle.
- `req_addr` out ADDR_W: folded bucket address of the head entry.
- `req_id` out 32: ID of the head entry.
- `q_count` out DEPTH_LOG2+1: current occupancy.
- `q_full` out 1: occupancy equals 2^DEPTH_LOG2.
- `q_empty` out 1: occupancy is 0.
- `overflow` out 1: one-cycle pulse for each dropped entry.
- `drop_count` out 16: present only with `HASH_QUEUE_STATS_EN`.
- `hwm` out DEPTH_LOG2+1: present only with `HASH_QUEUE_STATS_EN`.

## Operation
- **Fold stage (registered).** On `hash_valid`, it captures `hash_id` and `addr = hash_data[ADDR_W-1:0] ^ (hash_data >> ADDR_W)[ADDR_W-1:0]`, and sets `fold_vld` to 1; otherwise `fold_vld` is 0.
  - `hash_valid` is authoritative: a zero hash with valid set is a legal entry, and nonzero data without valid is ignored.
- **Push.** Occurs when `fold_vld` is 1 and the FIFO is not full at that edge.
  - "Not full" counts a pop on the same edge, so a full FIFO with a simultaneous pop accepts the push and `q_count` is unchanged.
- **Pop.** Occurs when `req_valid && req_ready`. `req_ready` is ignored while empty.
- **Drop.** When `fold_vld` is 1, the FIFO is full and there is no pop, the entry is discarded. `overflow` is 1 in the next cycle, and existing contents are untouched.
- **Pointers.** Read and write pointers are DEPTH_LOG2 bits and wrap modulo the depth. `q_count` changes by +1 on push only, −1 on pop only, and 0 on both or neither.
- **Ordering.** Strictly FIFO, with no reordering and no duplicate suppression.
- **Output stability.** `req_addr`/`req_id` reflect the head entry and hold stable while `req_valid && !req_ready`.

## Timing
- Reset values (the cycle after reset is sampled high): `req_valid`=0, `req_addr`=0, `req_id`=0, `q_count`=0, `q_empty`=1, `q_full`=0, `overflow`=0, `drop_count`=0, `hwm`=0, `fold_vld`=0, both pointers 0.
- Latency: `hash_valid` in cycle N → fold register at the end of N → FIFO write at the end of N+1 → `req_valid`=1 in cycle N+2 when previously empty. There is no combinational path from inputs to outputs.
- Throughput: one push and one pop per cycle.
- Reset mid-operation:
  - All queued entries and the fold stage are discarded.
  - Inputs presented during the reset cycle are ignored.
  - Outputs hold their reset values from the next cycle.

## Configuration
- `HASH_QUEUE_STATS_EN` defined:
  - `drop_count` increments on every drop and saturates at 16'hFFFF.
  - `hwm` holds the maximum `q_count` seen since reset.
- Not defined: both ports and their registers are absent. Queue behaviour is identical either way.

## Structure
- Shared package `hash_queue_pkg`:
  - `ADDR_W`/`DEPTH_LOG2` defaults and legal bounds.
  - The FIFO entry type `{id[31:0], addr[ADDR_W-1:0]}`.
  - The fold function.
- Sub-module `hash_queue_fifo`: storage array, pointers, count and full/empty.
- The top level holds the fold stage, drop logic and stats.

## Test plan
- **Reset:** assert reset for 3 cycles with `hash_valid`=1 → all outputs at reset values, `q_empty`=1, nothing queued afterwards.
- **Single entry:** `ADDR_W`=19, `hash_data`=32'h8000_0001, `hash_id`=32'h42 in cycle N, `req_ready`=1 → `req_valid`=1 in N+2 with `req_addr`=19'h01001 and `req_id`=32'h42; `q_empty`=1 again in N+3.
- **Backpressure fill:** `req_ready`=0, 20 consecutive valid inputs with IDs 1..20 → `q_count`=16, `q_full`=1, `overflow` pulses 4 times, `drop_count`=4, `hwm`=16. Raising `req_ready` then drains IDs 1..16 in order.
- **Full push+pop:** FIFO at 16, one valid input coinciding with a pop → `q_count` stays 16, no `overflow`, and the new ID lands at the tail.
- **Zero hash vs invalid:** `hash_valid`=1 with `hash_data`=0 → entry queued with `req_addr`=0. `hash_valid`=0 with `hash_data`=32'hFFFF_FFFF → no entry.
- **Reset mid-operation:** 5 entries queued plus one in the fold stage, 1-cycle reset → `q_count`=0 and `req_valid`=0 the next cycle, and no stale entry emerges later.

Source files
------------

// File: rtl/hash_queue_pkg.sv
// Shared definitions for the hash bucket queue: parameter defaults and bounds,
// the FIFO entry layout and the hash-to-bucket fold.
package hash_queue_pkg;

    localparam int ADDR_W_DEF     = 19;
    localparam int ADDR_W_MIN     = 8;
    localparam int ADDR_W_MAX     = 20;
    localparam int DEPTH_LOG2_DEF = 4;
    localparam int DEPTH_LOG2_MIN = 2;
    localparam int DEPTH_LOG2_MAX = 8;

    // addr is sized for the widest legal bucket address; bits above ADDR_W stay zero
    typedef struct packed {
        logic [31:0]           id;
        logic [ADDR_W_MAX-1:0] addr;
    } hq_entry_t;

    localparam int ENTRY_W = $bits(hq_entry_t);

    function automatic logic [ADDR_W_MAX-1:0] fold_hash(input logic [31:0] data, input int addr_w);
        logic [31:0] mixed;
        logic [31:0] mask;
        mixed = data ^ (data >> addr_w);
        mask  = (32'd1 << addr_w) - 32'd1;
        mixed = mixed & mask;
        return mixed[ADDR_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/hash_queue_fifo.sv
// Circular FIFO with show-ahead head: storage array, wrap-around pointers,
// occupancy count and full/empty flags. Caller only asserts push/pop when legal.
module hash_queue_fifo
    import hash_queue_pkg::*;
#(
    parameter int W          = ENTRY_W,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                push,
    input  logic                pop,
    input  logic [W-1:0]        wdata,
    output logic [W-1:0]        rdata,
    output logic [DEPTH_LOG2:0] count,
    output logic                full,
    output logic                empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
        end
    end

    // Head is forced to zero while empty so stale storage never shows on the outputs
    assign rdata = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == CNT_FULL);
    assign empty = (count_reg == '0);

endmodule

// File: rtl/hash_bucket_queue.sv
// Folds incoming hashes into bucket addresses and queues them for SRAM lookup,
// dropping (and flagging) on overflow. Optional stats via HASH_QUEUE_STATS_EN.
module hash_bucket_queue
    import hash_queue_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  hash_valid,
    input  logic [31:0]           hash_data,
    input  logic [31:0]           hash_id,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_W-1:0]     req_addr,
    output logic [31:0]           req_id,
    output logic [DEPTH_LOG2:0]   q_count,
    output logic                  q_full,
    output logic                  q_empty,
    output logic                  overflow
`ifdef HASH_QUEUE_STATS_EN
    ,
    output logic [15:0]           drop_count,
    output logic [DEPTH_LOG2:0]   hwm
`endif
);

    logic                fold_vld_reg;
    hq_entry_t           fold_entry_reg;
    logic                overflow_reg;
    logic                push;
    logic                pop;
    logic                drop;
    logic [ENTRY_W-1:0]  head_bits;
    hq_entry_t           head;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                empty;
    logic                unused_head_addr;

    // A pop on the same edge frees a slot, so a full queue still accepts the push
    assign pop  = !empty && req_ready;
    assign push = fold_vld_reg && (!full || pop);
    assign drop = fold_vld_reg && full && !pop;

    always_ff @(posedge axi_aclk) begin
        if (axi_aresetn) begin
            fold_vld_reg   <= 1'b0;
            fold_entry_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            fold_vld_reg <= hash_valid;
            if (hash_valid) begin
                fold_entry_reg.id   <= hash_id;
                fold_entry_reg.addr <= fold_hash(hash_data, ADDR_W);
            end
            overflow_reg <= drop;
        end
    end

    hash_queue_fifo #(
        .W          (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (axi_aclk),
        .srst  (axi_aresetn),
        .push  (push),
        .pop   (pop),
        .wdata (fold_entry_reg),
        .rdata (head_bits),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign head             = hq_entry_t'(head_bits);
    assign unused_head_addr = ^head.addr;
    assign req_valid        = !empty;
    assign req_addr         = head.addr[ADDR_W-1:0];
    assign req_id           = head.id;
    assign q_count          = count;
    assign q_full           = full;
    assign q_empty          = empty;
    assign overflow         = overflow_reg;

`ifdef HASH_QUEUE_STATS_EN
    localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [15:0]         drop_count_reg;
    logic [DEPTH_LOG2:0] hwm_reg;

    // hwm never lags count, so it can only grow on a push-only edge at the mark
    always_ff @(posedge axi_aclk) begin
        if (axi_aresetn) begin
            drop_count_reg <= '0;
            hwm_reg        <= '0;
        end else begin
            if (drop && (drop_count_reg != 16'hFFFF)) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
            if (push && !pop && (count == hwm_reg)) begin
                hwm_reg <= hwm_reg + CNT_ONE;
            end
        end
    end

    assign drop_count = drop_count_reg;
    assign hwm        = hwm_reg;
`endif

endmodule

// File: tb/tb_hash_bucket_queue.sv
// Scoreboard bench for hash_bucket_queue: a queue-level reference model feeds
// expected entries; a negedge monitor checks every cycle.
module tb_hash_bucket_queue;

    localparam int AW    = 19;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hv  = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] hd  = '0;
    logic [31:0] hi  = '0;

    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_id;
    logic [DL:0]   q_count;
    logic          q_full;
    logic          q_empty;
    logic          overflow;
`ifdef HASH_QUEUE_STATS_EN
    logic [15:0]   drop_count;
    logic [DL:0]   hwm;
`endif

    always #5 clk = ~clk;

    hash_bucket_queue #(.ADDR_W(AW), .DEPTH_LOG2(DL)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst),
        .hash_valid  (hv),
        .hash_data   (hd),
        .hash_id     (hi),
        .req_valid   (req_valid),
        .req_ready   (rdy),
        .req_addr    (req_addr),
        .req_id      (req_id),
        .q_count     (q_count),
        .q_full      (q_full),
        .q_empty     (q_empty),
        .overflow    (overflow)
`ifdef HASH_QUEUE_STATS_EN
        ,
        .drop_count  (drop_count),
        .hwm         (hwm)
`endif
    );

    typedef struct {
        logic [31:0]   id;
        logic [AW-1:0] addr;
    } ent_t;

    int   tests    = 0;
    int   fails    = 0;
    bit   checking = 1'b0;
    ent_t sb_q[$];

    // Reference model: pending fold item plus queue occupancy
    bit   m_fold_v = 1'b0;
    ent_t m_fold;
    int   m_count  = 0;
    bit   m_ovf    = 1'b0;
    int   m_drops  = 0;
    int   m_hwm    = 0;

    function automatic logic [AW-1:0] ref_fold(input logic [31:0] d);
        logic [31:0] upper;
        upper = d >> AW;
        return d[AW-1:0] ^ upper[AW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, applying the current inputs to the model as well
    task automatic step();
        bit   pop_m;
        bit   push_m;
        int   n_count;
        bit   n_ovf;
        bit   n_fold_v;
        ent_t n_fold;
        ent_t pushed;
        pushed = m_fold;
        push_m = 1'b0;
        pop_m  = 1'b0;
        if (rst) begin
            n_count  = 0;
            n_ovf    = 1'b0;
            n_fold_v = 1'b0;
        end else begin
            pop_m    = (m_count > 0) && rdy;
            push_m   = m_fold_v && ((m_count < DEPTH) || pop_m);
            n_count  = m_count + int'(push_m) - int'(pop_m);
            n_ovf    = m_fold_v && !push_m;
            n_fold_v = hv;
        end
        n_fold.id   = hi;
        n_fold.addr = ref_fold(hd);
        @(posedge clk);
        #1;
        if (rst) begin
            sb_q.delete();
            m_drops  = 0;
            m_hwm    = 0;
            checking = 1'b1;
        end else begin
            if (push_m) sb_q.push_back(pushed);
            if (n_ovf && m_drops < 65535) m_drops++;
            if (n_count > m_hwm) m_hwm = n_count;
        end
        m_count  = n_count;
        m_ovf    = n_ovf;
        m_fold_v = n_fold_v;
        m_fold   = n_fold;
    endtask

    // Monitor: compare outputs mid-cycle and retire the head on each handshake
    always begin
        @(negedge clk);
        if (checking) begin
            chk("req_valid", 32'(req_valid), 32'(m_count != 0));
            chk("q_count", 32'(q_count), m_count);
            chk("q_full", 32'(q_full), 32'(m_count == DEPTH));
            chk("q_empty", 32'(q_empty), 32'(m_count == 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (m_count != 0) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard: got head id %0h expected no entry at %0t", req_id, $time);
                end else begin
                    chk("req_addr", 32'(req_addr), 32'(sb_q[0].addr));
                    chk("req_id", req_id, sb_q[0].id);
                    if (rdy) void'(sb_q.pop_front());
                end
            end else begin
                chk("req_addr_idle", 32'(req_addr), 32'd0);
                chk("req_id_idle", req_id, 32'd0);
            end
`ifdef HASH_QUEUE_STATS_EN
            chk("drop_count", 32'(drop_count), m_drops);
            chk("hwm", 32'(hwm), m_hwm);
`endif
        end
    end

    initial begin
        int ovf_seen;
        int pcts[4];
        pcts = '{90, 10, 50, 0};

        // Reset held 3 cycles with valid input
        rst = 1'b1; hv = 1'b1; hd = 32'h1234_5678; hi = 32'h55;
        for (int i = 0; i < 3; i++) step();
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_q_empty", 32'(q_empty), 32'd1);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0; hv = 1'b0;
        step(); step();
        chk("rst_nothing_queued", 32'(q_empty), 32'd1);

        // Single entry latency
        rdy = 1'b1; hv = 1'b1; hd = 32'h8000_0001; hi = 32'h42;
        step();
        chk("single_not_early", 32'(req_valid), 32'd0);
        hv = 1'b0;
        step();
        chk("single_valid", 32'(req_valid), 32'd1);
        chk("single_addr", 32'(req_addr), 32'h0000_1001);
        chk("single_id", req_id, 32'h42);
        step();
        chk("single_empty_after", 32'(q_empty), 32'd1);

        // Backpressure fill with 20 inputs
        rdy = 1'b0;
        ovf_seen = 0;
        for (int i = 1; i <= 23; i++) begin
            hv = (i <= 20);
            hi = i;
            hd = $urandom;
            step();
            if (overflow) ovf_seen++;
        end
        hv = 1'b0;
        chk("fill_overflows", ovf_seen, 32'd4);
        chk("fill_count", 32'(q_count), 32'd16);
        chk("fill_full", 32'(q_full), 32'd1);
`ifdef HASH_QUEUE_STATS_EN
        chk("fill_drop_count", 32'(drop_count), 32'd4);
        chk("fill_hwm", 32'(hwm), 32'd16);
`endif

        // Full queue with simultaneous push and pop
        hv = 1'b1; hi = 32'd99; hd = $urandom;
        step();
        hv = 1'b0; rdy = 1'b1;
        chk("pp_head", req_id, 32'd1);
        step();
        chk("pp_count", 32'(q_count), 32'd16);
        chk("pp_no_overflow", 32'(overflow), 32'd0);
        for (int k = 0; k < 16; k++) begin
            chk("drain_order", req_id, (k < 15) ? 32'(k + 2) : 32'd99);
            step();
        end
        chk("drain_empty", 32'(q_empty), 32'd1);

        // Zero hash with valid is queued, all-ones without valid is not
        rdy = 1'b0; hv = 1'b1; hd = 32'h0; hi = 32'd7;
        step();
        hv = 1'b0; hd = 32'hFFFF_FFFF; hi = 32'd8;
        step(); step();
        chk("zero_valid", 32'(req_valid), 32'd1);
        chk("zero_addr", 32'(req_addr), 32'd0);
        chk("zero_id", req_id, 32'd7);
        step(); step();
        chk("invalid_ignored", 32'(q_count), 32'd1);
        rdy = 1'b1; hd = 32'h0;
        step();
        chk("zero_drained", 32'(q_empty), 32'd1);

        // Reset with 5 queued and one in the fold stage
        rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            hv = 1'b1; hi = 100 + i; hd = $urandom;
            step();
        end
        chk("mid_prefill", 32'(q_count), 32'd5);
        rst = 1'b1; hi = 32'd77;
        step();
        rst = 1'b0; hv = 1'b0;
        chk("mid_count", 32'(q_count), 32'd0);
        chk("mid_valid", 32'(req_valid), 32'd0);
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mid_no_stale", 32'(req_valid), 32'd0);
        end

        // Randomized traffic with varying backpressure and rare resets
        for (int c = 0; c < 2000; c++) begin
            hv  = ($urandom_range(0, 3) != 0);
            hd  = $urandom;
            hi  = 32'(c) + 32'h1000;
            rdy = ($urandom_range(0, 99) < pcts[(c / 200) % 4]);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; hv = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("final_empty", 32'(q_empty), 32'd1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
